// File: rtl/act_relu_quant.sv
// Activation stage ahead of the 2x2 max-pooling block.
// Adds a per-layer bias to each accumulator result, applies ReLU, requantizes
// to unsigned DATA_WIDTH with a round-half-up right shift and saturation, and
// tags every result with a sequential (wrapping) address. Fixed 3-cycle latency,
// one sample per cycle, no backpressure.
module act_relu_quant #(
    parameter int ACC_WIDTH     = 20,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10,
    parameter int SHIFT_WIDTH   = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_start_i,
    input  logic signed [ACC_WIDTH-1:0]   cfg_bias_i,
    input  logic [SHIFT_WIDTH-1:0]        cfg_shift_i,
    input  logic [ADDRESS_WIDTH-1:0]      cfg_base_addr_i,
    input  logic                          acc_valid_i,
    input  logic signed [ACC_WIDTH-1:0]   acc_data_i,
    input  logic                          acc_last_i,
    output logic                          act_valid_o,
    output logic [DATA_WIDTH-1:0]         act_result_o,
    output logic [ADDRESS_WIDTH-1:0]      act_result_address_o,
    output logic                          act_last_o,
    output logic                          busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Per-layer configuration
    logic signed [ACC_WIDTH-1:0]   bias_q;
    logic [SHIFT_WIDTH-1:0]        shift_q;
    logic [ADDRESS_WIDTH-1:0]      addr_cnt_q, addr_cnt_d;

    // Stage 1: biased sum
    logic                          s1_vld_q;
    logic                          s1_last_q;
    logic signed [ACC_WIDTH:0]     s1_sum_q;

    // Stage 2: ReLU + rounding shift
    logic                          s2_vld_q;
    logic                          s2_last_q;
    logic [ACC_WIDTH+1:0]          s2_r_q;

    // Stage 3: saturated output registers
    logic                          act_valid_q;
    logic                          act_last_q;
    logic [DATA_WIDTH-1:0]         act_result_q;
    logic [ADDRESS_WIDTH-1:0]      act_addr_q;

    logic                          accept;
    logic                          cfg_load;
    logic                          pipe_empty;

    // ReLU followed by round-half-up right shift. The sum is known positive when
    // shifting, so the work is done unsigned in ACC_WIDTH+2 bits. Shift amounts
    // beyond the word width collapse to 0 naturally.
    function automatic logic [ACC_WIDTH+1:0] relu_round(
        input logic signed [ACC_WIDTH:0] sum,
        input logic [SHIFT_WIDTH-1:0]    sh
    );
        logic [ACC_WIDTH+1:0] ext;
        logic [ACC_WIDTH+1:0] one;
        logic [ACC_WIDTH+1:0] res;
        ext = {1'b0, sum};
        one = {{(ACC_WIDTH+1){1'b0}}, 1'b1};
        if (sum[ACC_WIDTH] || (sum == '0)) begin
            res = '0;
        end else if (sh == '0) begin
            res = ext;
        end else begin
            res = (ext + (one << (sh - 1'b1))) >> sh;
        end
        return res;
    endfunction

    // Clamp to the largest unsigned DATA_WIDTH value.
    function automatic logic [DATA_WIDTH-1:0] saturate(input logic [ACC_WIDTH+1:0] r);
        if (|r[ACC_WIDTH+1:DATA_WIDTH]) begin
            return '1;
        end
        return r[DATA_WIDTH-1:0];
    endfunction

    assign accept     = (state_q == RUN) && acc_valid_i;
    assign cfg_load   = (state_q == IDLE) && cfg_start_i;
    assign pipe_empty = !s1_vld_q && !s2_vld_q && !act_valid_q;

    // Layer sequencing: arm on start, drain after the last sample, then idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_start_i) state_d = RUN;
            RUN:     if (acc_valid_i && acc_last_i) state_d = DRAIN;
            DRAIN:   if (pipe_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address counter: loaded with the base at layer start, advances per output.
    always_comb begin
        addr_cnt_d = addr_cnt_q;
        if (cfg_load) begin
            addr_cnt_d = cfg_base_addr_i;
        end else if (s2_vld_q) begin
            addr_cnt_d = addr_cnt_q + 1'b1;
        end
    end

    // State, configuration, counter and valid/last tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bias_q      <= '0;
            shift_q     <= '0;
            addr_cnt_q  <= '0;
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_last_q   <= 1'b0;
            act_valid_q <= 1'b0;
            act_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_cnt_q  <= addr_cnt_d;
            if (cfg_load) begin
                bias_q  <= cfg_bias_i;
                shift_q <= cfg_shift_i;
            end
            s1_vld_q    <= accept;
            s1_last_q   <= accept && acc_last_i;
            s2_vld_q    <= s1_vld_q;
            s2_last_q   <= s1_last_q;
            act_valid_q <= s2_vld_q;
            act_last_q  <= s2_last_q;
        end
    end

    // Output data registers hold their value between valid results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_result_q <= '0;
            act_addr_q   <= '0;
        end else if (s2_vld_q) begin
            act_result_q <= saturate(s2_r_q);
            act_addr_q   <= addr_cnt_q;
        end
    end

    // Datapath stages 1 and 2; only captured when a sample is present.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_sum_q <= {acc_data_i[ACC_WIDTH-1], acc_data_i} + {bias_q[ACC_WIDTH-1], bias_q};
        end
        if (s1_vld_q) begin
            s2_r_q <= relu_round(s1_sum_q, shift_q);
        end
    end

    assign act_valid_o          = act_valid_q;
    assign act_last_o           = act_last_q;
    assign act_result_o         = act_result_q;
    assign act_result_address_o = act_addr_q;
    assign busy_o               = (state_q != IDLE);

endmodule

// File: tb/tb_act_relu_quant.sv
// Directed bench for act_relu_quant: hand-computed vectors, immediate assertions.
module tb_act_relu_quant;

    logic               clk;
    logic               rst;
    logic               cfg_start;
    logic signed [19:0] cfg_bias;
    logic [4:0]         cfg_shift;
    logic [9:0]         cfg_base;
    logic               acc_valid;
    logic signed [19:0] acc_data;
    logic               acc_last;
    logic               act_valid;
    logic [7:0]         act_result;
    logic [9:0]         act_addr;
    logic               act_last;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    act_relu_quant #(
        .ACC_WIDTH    (20),
        .DATA_WIDTH   (8),
        .ADDRESS_WIDTH(10),
        .SHIFT_WIDTH  (5)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cfg_start_i         (cfg_start),
        .cfg_bias_i          (cfg_bias),
        .cfg_shift_i         (cfg_shift),
        .cfg_base_addr_i     (cfg_base),
        .acc_valid_i         (acc_valid),
        .acc_data_i          (acc_data),
        .acc_last_i          (acc_last),
        .act_valid_o         (act_valid),
        .act_result_o        (act_result),
        .act_result_address_o(act_addr),
        .act_last_o          (act_last),
        .busy_o              (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic start, input logic signed [19:0] b,
                           input logic [4:0] s, input logic [9:0] a);
        cfg_start = start;
        cfg_bias  = b;
        cfg_shift = s;
        cfg_base  = a;
    endtask

    task automatic send(input logic v, input logic signed [19:0] d, input logic l);
        acc_valid = v;
        acc_data  = d;
        acc_last  = l;
    endtask

    task automatic check_busy(input string tag, input logic b);
        checks++;
        assert (busy === b) else begin
            failures++;
            $error("FAIL %s busy observed=%0b expected=%0b", tag, busy, b);
        end
    endtask

    // No result this cycle: valid and last both low.
    task automatic check_none(input string tag);
        checks++;
        assert (act_valid === 1'b0) else begin
            failures++;
            $error("FAIL %s valid observed=%0b expected=0", tag, act_valid);
        end
        checks++;
        assert (act_last === 1'b0) else begin
            failures++;
            $error("FAIL %s last observed=%0b expected=0", tag, act_last);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] r,
                             input logic [9:0] a, input logic l);
        checks++;
        assert (act_valid === v) else begin
            failures++;
            $error("FAIL %s valid observed=%0b expected=%0b", tag, act_valid, v);
        end
        checks++;
        assert (act_result === r) else begin
            failures++;
            $error("FAIL %s result observed=%0d expected=%0d", tag, act_result, r);
        end
        checks++;
        assert (act_addr === a) else begin
            failures++;
            $error("FAIL %s address observed=%0d expected=%0d", tag, act_addr, a);
        end
        checks++;
        assert (act_last === l) else begin
            failures++;
            $error("FAIL %s last observed=%0b expected=%0b", tag, act_last, l);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_cfg(1'b0, 20'sd0, 5'd0, 10'd0);
        send(1'b0, 20'sd0, 1'b0);
        #1 rst = 1'b0;
        tick();
        tick();
        check_out("reset_out", 1'b0, 8'd0, 10'd0, 1'b0);
        check_busy("reset_busy", 1'b0);
        rst = 1'b1;
        tick();

        // Layer 1: bias 0, shift 0, base 0. A sample coinciding with the start is dropped.
        set_cfg(1'b1, 20'sd0, 5'd0, 10'd0);
        send(1'b1, 20'sd55, 1'b0);
        tick();
        check_busy("l1_busy_run", 1'b1);
        set_cfg(1'b0, 20'sd0, 5'd0, 10'd0);
        send(1'b1, 20'sd100, 1'b0);
        tick();
        check_none("l1_lat1");
        send(1'b1, -20'sd5, 1'b0);
        tick();
        check_none("l1_drop_start_sample");
        send(1'b1, 20'sd300, 1'b0);
        tick();
        check_out("l1_s100", 1'b1, 8'd100, 10'd0, 1'b0);
        // Restart attempt during RUN must be ignored.
        send(1'b0, 20'sd0, 1'b0);
        set_cfg(1'b1, -20'sd10, 5'd2, 10'd500);
        tick();
        check_out("l1_neg", 1'b1, 8'd0, 10'd1, 1'b0);
        set_cfg(1'b0, 20'sd0, 5'd0, 10'd0);
        send(1'b1, 20'sd7, 1'b1);
        tick();
        check_out("l1_sat", 1'b1, 8'd255, 10'd2, 1'b0);
        send(1'b0, 20'sd0, 1'b0);
        tick();
        check_out("l1_hold", 1'b0, 8'd255, 10'd2, 1'b0);
        check_busy("l1_busy_drain", 1'b1);
        tick();
        check_out("l1_last", 1'b1, 8'd7, 10'd3, 1'b1);
        tick();
        check_none("l1_after_last");
        check_busy("l1_busy_empty", 1'b1);
        tick();
        check_busy("l1_busy_idle", 1'b0);

        // Samples in IDLE produce nothing.
        send(1'b1, 20'sd50, 1'b0);
        tick();
        check_none("idle_ign0");
        tick();
        check_none("idle_ign1");
        tick();
        check_none("idle_ign2");
        send(1'b0, 20'sd0, 1'b0);
        tick();
        check_none("idle_ign3");
        check_busy("idle_busy", 1'b0);

        // Layer 2: bias -10, shift 2, base 1022 with address wrap and saturation after rounding.
        set_cfg(1'b1, -20'sd10, 5'd2, 10'd1022);
        tick();
        set_cfg(1'b0, 20'sd0, 5'd0, 10'd0);
        send(1'b1, 20'sd6, 1'b0);
        tick();
        send(1'b1, 20'sd16, 1'b0);
        tick();
        send(1'b1, 20'sd13, 1'b0);
        tick();
        check_out("l2_relu", 1'b1, 8'd0, 10'd1022, 1'b0);
        send(1'b1, 20'sd1034, 1'b1);
        tick();
        check_out("l2_round6", 1'b1, 8'd2, 10'd1023, 1'b0);
        send(1'b0, 20'sd0, 1'b0);
        tick();
        check_out("l2_round3_wrap", 1'b1, 8'd1, 10'd0, 1'b0);
        tick();
        check_out("l2_last_sat", 1'b1, 8'd255, 10'd1, 1'b1);
        tick();
        check_none("l2_drained");
        check_busy("l2_busy_empty", 1'b1);
        tick();
        check_busy("l2_busy_idle", 1'b0);

        // Layer 3: bias 5, shift 1, base 10 with a valid bubble.
        set_cfg(1'b1, 20'sd5, 5'd1, 10'd10);
        tick();
        set_cfg(1'b0, 20'sd0, 5'd0, 10'd0);
        send(1'b1, 20'sd20, 1'b0);
        tick();
        send(1'b0, 20'sd0, 1'b0);
        tick();
        send(1'b1, 20'sd0, 1'b0);
        tick();
        check_out("l3_b0", 1'b1, 8'd13, 10'd10, 1'b0);
        send(1'b0, 20'sd0, 1'b0);
        tick();
        check_out("l3_bubble", 1'b0, 8'd13, 10'd10, 1'b0);
        tick();
        check_out("l3_b1", 1'b1, 8'd3, 10'd11, 1'b0);
        tick();
        check_none("l3_gap");

        // Reset mid-layer with two samples in flight.
        send(1'b1, 20'sd100, 1'b0);
        tick();
        tick();
        send(1'b0, 20'sd0, 1'b0);
        rst = 1'b0;
        #1;
        check_out("rst_mid_out", 1'b0, 8'd0, 10'd0, 1'b0);
        check_busy("rst_mid_busy", 1'b0);
        tick();
        check_none("rst_hold0");
        rst = 1'b1;
        tick();
        check_none("rst_after0");
        tick();
        check_out("rst_after1", 1'b0, 8'd0, 10'd0, 1'b0);
        check_busy("rst_after_busy", 1'b0);

        // Single-sample layer from a new base.
        set_cfg(1'b1, 20'sd0, 5'd0, 10'd700);
        tick();
        set_cfg(1'b0, 20'sd0, 5'd0, 10'd0);
        send(1'b1, 20'sd42, 1'b1);
        tick();
        send(1'b0, 20'sd0, 1'b0);
        tick();
        check_none("single_lat");
        tick();
        check_out("single_out", 1'b1, 8'd42, 10'd700, 1'b1);
        tick();
        check_none("single_after");
        tick();
        check_busy("single_idle", 1'b0);

        // Large shift: (524288 + 2^19) >> 20 = 1, (4 + 2^19) >> 20 = 0.
        set_cfg(1'b1, 20'sd1, 5'd20, 10'd5);
        tick();
        set_cfg(1'b0, 20'sd0, 5'd0, 10'd0);
        send(1'b1, 20'sd524287, 1'b0);
        tick();
        send(1'b1, 20'sd3, 1'b1);
        tick();
        send(1'b0, 20'sd0, 1'b0);
        tick();
        check_out("shift20_one", 1'b1, 8'd1, 10'd5, 1'b0);
        tick();
        check_out("shift20_zero", 1'b1, 8'd0, 10'd6, 1'b1);
        tick();
        tick();
        check_busy("shift20_idle", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/act_relu_quant.md
Name: act_relu_quant

Overview:
- Activation stage directly upstream of the 2x2 max-pooling block. Takes signed accumulator results from the PE array/accumulator, adds a per-layer bias, applies ReLU, requantizes to unsigned DATA_WIDTH with rounding right-shift and saturation, and tags each result with a sequential address.
- Outputs drive the pooling block's act_valid_i / act_result_i / act_result_address_i / act_last_i one-to-one.
- No backpressure: the pooling stage always accepts.

Parameters:
- ACC_WIDTH, 20, width of signed accumulator input
- DATA_WIDTH, 8, width of unsigned activation output
- ADDRESS_WIDTH, 10, width of output address
- SHIFT_WIDTH, 5, width of requantization shift amount

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_start_i  in  1  one-cycle pulse; latches config and arms the block for one layer
- cfg_bias_i  in  ACC_WIDTH  signed bias, sampled on cfg_start_i
- cfg_shift_i  in  SHIFT_WIDTH  right-shift amount, sampled on cfg_start_i
- cfg_base_addr_i  in  ADDRESS_WIDTH  first output address, sampled on cfg_start_i
- acc_valid_i  in  1  accumulator sample valid
- acc_data_i  in  ACC_WIDTH  signed accumulator value
- acc_last_i  in  1  marks the final sample of the layer; qualified by acc_valid_i
- act_valid_o  out  1  activation result valid
- act_result_o  out  DATA_WIDTH  unsigned activation result
- act_result_address_o  out  ADDRESS_WIDTH  address of the result
- act_last_o  out  1  asserted with the final result of the layer
- busy_o  out  1  high in RUN or DRAIN

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE; all pipeline valid bits clear.
  - All outputs are 0; address counter, latched bias/shift/base are 0.
- FSM states:
  - IDLE: on cfg_start_i, latch bias, shift and base address; load counter = base; go to RUN. acc_valid_i is ignored in IDLE.
  - RUN: each acc_valid_i=1 sample enters the pipeline. A sample with acc_valid_i & acc_last_i goes to DRAIN (that sample is still processed). cfg_start_i is ignored.
  - DRAIN: input is ignored; stay until all three pipeline stages are empty, then go to IDLE. cfg_start_i is ignored.
  - busy_o = (state != IDLE).
- Pipeline: 3 stages, fixed latency of 3 cycles from an accepted acc_valid_i to act_valid_o. Each stage carries valid and last. Full throughput (one sample per cycle); gaps in acc_valid_i propagate as gaps.
  - S1: sum = sign-extended acc_data_i + bias, ACC_WIDTH+1 bits signed, no overflow possible.
  - S2:
    - If sum <= 0, the result is 0 (ReLU).
    - Otherwise, if shift = 0, r = sum; if shift > 0, r = (sum + (1 << (shift-1))) >> shift (round half up, computed in ACC_WIDTH+2 bits).
    - shift >= ACC_WIDTH+1 gives r = 0 or 1 per the rounding formula.
  - S3: act_result_o = min(r, 2^DATA_WIDTH - 1), i.e. saturate. Output registers are updated only when valid.
- Addressing:
  - act_result_address_o = counter value at output.
  - Counter increments by 1 after each valid output and wraps modulo 2^ADDRESS_WIDTH (1023 -> 0).
- act_last_o:
  - High exactly on the output cycle of the sample accepted with acc_last_i; act_valid_o is also high that cycle.
  - act_last_o is never high without act_valid_o.
- act_valid_o / act_last_o are single-cycle per sample. act_result_o and act_result_address_o hold their last values while act_valid_o = 0.
- Simultaneous cfg_start_i and acc_valid_i in IDLE: config is latched, the sample is dropped.
- Layer with a single sample carrying acc_last_i: one output with act_last_o=1, address = base.
- Reset mid-layer: in-flight samples are discarded, no further act_valid_o, FSM in IDLE.

Test Plan:
- bias=0, shift=0, base=0; acc = 100, -5, 300 back-to-back -> act_result 100, 0, 255 at addresses 0, 1, 2; first act_valid_o 3 cycles after the first acc_valid_i.
- bias=-10, shift=2; acc = 6, 16, 13 -> sums -4, 6, 3 -> results 0, 2 (6+2=8>>2), 1 (3+2=5>>2).
- base=1022; 4 samples, the last with acc_last_i -> addresses 1022, 1023, 0, 1; act_last_o only with the 4th; busy_o drops the cycle after DRAIN empties.
- acc_valid_i pulses while in IDLE before cfg_start_i -> no act_valid_o. cfg_start_i pulsed during RUN -> counter and bias unchanged.
- Valid bubbles (valid 1,0,1) -> outputs show the same 1,0,1 pattern with consecutive addresses.
- rst asserted 1 cycle after 2 samples enter -> act_valid_o stays 0, all outputs 0, busy_o=0; a new cfg_start_i then restarts from the new base.
